instr_encoder: RTL
==================

# instr_encoder

Sequential instruction-word encoder and program loader: the write-side counterpart of the core's instruction decoder. It accepts field-level instruction requests (opcode, registers, immediate) over a valid/ready handshake. Each request is packed into a 16-bit word in the same format the decoder consumes and buffered in a small FIFO. Words are then streamed into instruction memory at consecutive word addresses. It sits between the test/boot loader and the instruction memory write port.

## Interface
- DEPTH, 4: FIFO entries (power of two, ≥2)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; latches base_addr, clears counters/err, enters RUN
- base_addr  in  16  first write address (even)
- finish  in  1  pulse; end of program, enters FLUSH
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid & ready
- req_fmt  in  2  0=J, 1=I1, 2=I2, 3=R
- req_op  in  5  opcode → word[15:11]
- req_rs, req_rt, req_rd  in  3 each  register fields
- req_imm  in  11  immediate/displacement (low bits used)
- req_funct  in  2  R-format funct
- mem_wr_valid  out  1  write request
- mem_wr_ready  in  1  memory accepts write
- mem_addr  out  16  write address
- mem_wr_data  out  16  encoded word
- busy  out  1  state ≠ IDLE/DONE
- done  out  1  high in DONE
- err  out  1  sticky illegal-request flag
- word_cnt  out  16  words written since start

## Operation
- Packing: J = {op, imm[10:0]}, with imm forced to 0 for HALT 00000 / NOP 00001. I1 = {op, rs, rd, imm[4:0]}. I2 = {op, rs, imm[7:0]}. R = {op, rs, rt, rd, funct}.
- Legal opcode/format pairs:
  - J: 00000, 00001, 00100, 00110
  - I1: 01000–01011, 10000, 10001, 10011, 10100–10111
  - I2: 00101, 00111, 01100–01111, 10010, 11000
  - R: 11001, 11010, 11011, 11100–11111
- Illegal request (undefined opcode such as 00010/00011, or a format mismatch): the request is still accepted (consumed), no word is queued, and err is set until the next start.
- FSM: IDLE → (start) RUN → (finish) FLUSH → (FIFO empty, and auto-HALT done if enabled) DONE → (start) RUN.
- start in any state aborts: FIFO cleared, counters reset, RUN entered next cycle.
- finish outside RUN is ignored. start and finish in the same cycle: start wins.
- req_ready = (state==RUN) && (count<DEPTH). No push-on-full even when a pop occurs in the same cycle.
- mem_wr_valid = (count>0). mem_wr_data = FIFO head. mem_addr = base + 2·word_cnt, wrapping mod 2^16.
- A write completes on mem_wr_valid & mem_wr_ready: the FIFO pops and word_cnt increments.
- Push and pop in the same cycle leave count unchanged.

## Timing
- Reset values of all outputs: 0. State resets to IDLE, FIFO empty.
- Request accepted at edge N → word at FIFO head, mem_wr_valid high after edge N (when the FIFO was empty); earliest memory write at edge N+1.
- Sustained throughput is one word/cycle while mem_wr_ready=1.
- mem_wr_data and mem_addr stay stable while mem_wr_valid=1 and mem_wr_ready=0.
- done rises one cycle after the last write completes.
- Reset mid-operation discards queued words with no further writes.

## Configuration
- ENC_AUTO_HALT_EN defined: on entering FLUSH, one HALT word 16'h0000 is pushed as soon as the FIFO has space. DONE requires that word to be written, and word_cnt includes it.
- Not defined: FLUSH only drains the FIFO and no word is appended.

## Structure
- Shared package enc_pkg: format enum, opcode constants (same names as the decoder uses), legal-opcode table function, HALT_WORD constant.
- One sub-module: enc_fifo (DEPTH-entry synchronous FIFO, count/full/empty). Packing, legality checking and the FSM live in the top.

## Test plan
- start base=0x0100; R op 11011, rs=1, rt=2, rd=3, funct=00 → single write addr 0x0100 data 0xD94C, word_cnt=1.
- Back-to-back I1 01000 rs=1 rd=2 imm=5, then J 00100 imm=0x7FF, then I2 01100 rs=4 imm=0x10, with ready=1 → writes 0x4145@base, 0x27FF@base+2, 0x6410@base+4 on consecutive cycles.
- mem_wr_ready=0 for 10 cycles while 6 requests are offered (DEPTH=4) → req_ready drops after 4 accepts; on release, all 6 words are written in order with stable data during the stall.
- req_op=00010, or 11011 with fmt=I1 → request consumed, no write, err=1; the next start clears err.
- base=0xFFFE, two I2 11000 rs=1 imm=0xFF words → 0xC1FF@0xFFFE, 0xC1FF@0x0000 (wrap).
- finish with ENC_AUTO_HALT_EN → extra 0x0000 written, then done=1. Without the macro → done=1 once the FIFO empties. rst_n low mid-FLUSH → all outputs 0 immediately.

Source files
------------

// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - formats, opcodes, FSM states and opcode/format legality shared by the encoder
package enc_pkg;

    typedef enum logic [1:0] {
        FMT_J  = 2'd0,
        FMT_I1 = 2'd1,
        FMT_I2 = 2'd2,
        FMT_R  = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } enc_state_e;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;
    localparam logic [4:0] OP_JMP  = 5'b00100;
    localparam logic [4:0] OP_JAL  = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_LDI  = 5'b01100;
    localparam logic [4:0] OP_LUI  = 5'b11000;
    localparam logic [4:0] OP_ADD  = 5'b11001;

    localparam logic [15:0] HALT_WORD = 16'h0000;

    function automatic logic op_legal(input logic [4:0] op, input fmt_e fmt);
        fmt_e want;
        logic defined;
        want    = FMT_J;
        defined = 1'b1;
        case (op) inside
            5'b00000, 5'b00001, 5'b00100, 5'b00110:                       want = FMT_J;
            [5'b01000:5'b01011], 5'b10000, 5'b10001, 5'b10011,
            [5'b10100:5'b10111]:                                           want = FMT_I1;
            5'b00101, 5'b00111, [5'b01100:5'b01111], 5'b10010, 5'b11000:  want = FMT_I2;
            [5'b11001:5'b11111]:                                           want = FMT_R;
            default:                                                       defined = 1'b0;
        endcase
        return defined && (want == fmt);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request handshake and memory write port of the instruction encoder
interface instr_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_fmt;
    logic [4:0]  req_op;
    logic [2:0]  req_rs;
    logic [2:0]  req_rt;
    logic [2:0]  req_rd;
    logic [10:0] req_imm;
    logic [1:0]  req_funct;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_wr_data;

    modport master (
        output req_valid, req_fmt, req_op, req_rs, req_rt, req_rd, req_imm, req_funct,
        output mem_wr_ready,
        input  req_ready, mem_wr_valid, mem_addr, mem_wr_data
    );

    modport slave (
        input  req_valid, req_fmt, req_op, req_rs, req_rt, req_rd, req_imm, req_funct,
        input  mem_wr_ready,
        output req_ready, mem_wr_valid, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/enc_fifo.sv
// rtl/enc_fifo.sv - DEPTH-entry synchronous word FIFO with count/full/empty and synchronous clear
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage carries no reset; the head is only meaningful while count is non-zero
    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs field-level instruction requests into 16-bit words and streams them to instruction memory
// Build option ENC_AUTO_HALT_EN: append one HALT word when the program is finished.
module instr_encoder
    import enc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [15:0]    base_addr,
    input  logic           finish,
    instr_encoder_if.slave bus,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [15:0]    word_cnt
);
`ifdef ENC_AUTO_HALT_EN
    localparam logic AUTO_HALT = 1'b1;
`else
    localparam logic AUTO_HALT = 1'b0;
`endif
    localparam int CW = $clog2(DEPTH) + 1;

    enc_state_e  state_q;
    logic [15:0] base_q, word_cnt_q;
    logic        err_q, halt_pend_q;

    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [15:0]   fifo_head, packed_word, push_word;
    logic          req_fire, req_ok, push, pop;
    fmt_e          req_fmt;

    assign req_fmt       = fmt_e'(bus.req_fmt);
    assign bus.req_ready = (state_q == S_RUN) && !fifo_full;
    assign req_fire      = bus.req_valid && bus.req_ready;
    assign req_ok        = op_legal(bus.req_op, req_fmt);
    assign pop           = bus.mem_wr_valid && bus.mem_wr_ready;
    // The HALT word only goes in during FLUSH, where req_ready is low, so it never collides with a request
    assign push          = (req_fire && req_ok) || ((state_q == S_FLUSH) && halt_pend_q && !fifo_full);
    assign push_word     = req_fire ? packed_word : HALT_WORD;

    always_comb begin
        packed_word = {bus.req_op, bus.req_rs, bus.req_rt, bus.req_rd, bus.req_funct};
        case (req_fmt)
            FMT_J:   packed_word = {bus.req_op,
                                    (bus.req_op == OP_HALT || bus.req_op == OP_NOP) ? 11'd0 : bus.req_imm};
            FMT_I1:  packed_word = {bus.req_op, bus.req_rs, bus.req_rd, bus.req_imm[4:0]};
            FMT_I2:  packed_word = {bus.req_op, bus.req_rs, bus.req_imm[7:0]};
            default: ;
        endcase
    end

    enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (start),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_word),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            word_cnt_q  <= '0;
            err_q       <= 1'b0;
            halt_pend_q <= 1'b0;
        end else if (start) begin
            state_q     <= S_RUN;
            base_q      <= base_addr;
            word_cnt_q  <= '0;
            err_q       <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            if (pop)                 word_cnt_q <= word_cnt_q + 16'd1;
            if (req_fire && !req_ok) err_q      <= 1'b1;
            case (state_q)
                S_RUN: begin
                    if (finish) begin
                        state_q     <= S_FLUSH;
                        halt_pend_q <= AUTO_HALT;
                    end
                end
                S_FLUSH: begin
                    if (halt_pend_q) begin
                        if (!fifo_full) halt_pend_q <= 1'b0;
                    end else if (fifo_empty) begin
                        state_q <= S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_wr_valid = (fifo_count != '0);
    assign bus.mem_wr_data  = bus.mem_wr_valid ? fifo_head : 16'h0000;
    assign bus.mem_addr     = base_q + {word_cnt_q[14:0], 1'b0};
    assign busy             = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done             = (state_q == S_DONE);
    assign err              = err_q;
    assign word_cnt         = word_cnt_q;

endmodule
